mcif_write_ig_arb: RTL
======================

Name: mcif_write_ig_arb

Overview:
- Ingress-side write request arbiter for the MCIF write path. Shares one AXI AW issue slot among N write-DMA clients using round-robin.
- Enforces a programmable outstanding-beat budget. Budget is consumed at grant and returned by the egress completion strobe (eg2ig_axi_vld / eg2ig_axi_len).
- Sits between the per-client write request FIFOs and the AW/W formatter, upstream of the NOC.

Parameters:
- NUM_CLIENT, 5, number of write requesters (1..8); client index = AXI ID.
- CNT_W, 9, width of outstanding-beat counter (supports limit 0..255 plus 4-beat overshoot check).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  synchronous active-high reset
- req_vld  in  NUM_CLIENT  per-client request valid
- req_len  in  2*NUM_CLIENT  per-client burst length-1 (client i at [2i+1:2i]; 0..3 = 1..4 beats)
- req_rdy  out  NUM_CLIENT  per-client accept, one-hot or zero
- aw_vld  out  1  registered issue valid
- aw_id  out  3  granted client index
- aw_len  out  2  granted length-1
- aw_rdy  in  1  downstream accept
- eg2ig_axi_vld  in  1  completion return strobe
- eg2ig_axi_len  in  2  length-1 of completed burst
- reg2arb_os_limit  in  8  max outstanding beats; 0 blocks all grants
- reg2arb_wrr_weight  in  4*NUM_CLIENT  per-client weight (used only with the optional feature)
- arb2reg_os_cnt  out  CNT_W  current outstanding beats
- arb2reg_underflow  out  1  sticky credit-underflow flag

Behaviour:
- Reset (synchronous, active-high, nvdla_core_rst=1 at posedge):
  - aw_vld=0, aw_id=0, aw_len=0.
  - os_cnt=0, underflow=0, RR pointer=NUM_CLIENT-1 (so client 0 has first priority).
  - req_rdy=0 while reset is asserted.
  - Reset mid-burst drops the held request and clears credits; upstream must also be reset.
- Output stage is a 1-entry register with two states:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on aw_rdy with no new grant.
  - FULL -> FULL on aw_rdy with a same-cycle grant (back-to-back issue).
  - FULL with aw_rdy=0: aw_vld, aw_id and aw_len are held stable.
- Arbitration is evaluated when the stage is EMPTY, or FULL with aw_rdy=1:
  - Candidate = first requesting client after the RR pointer (wrapping).
  - Grant only if os_cnt + cand_len + 1 <= reg2arb_os_limit (CNT_W-bit compare).
  - If the candidate does not fit, stall: no skip to a shorter requester, no pointer move. This prevents starvation of 4-beat bursts.
- On grant:
  - req_rdy[cand]=1 combinationally in the same cycle.
  - Stage loads {cand, len}.
  - Pointer <= cand.
  - os_cnt += len+1.
  - Latency: req accept to aw_vld = 1 cycle.
- Credit return: eg2ig_axi_vld subtracts eg2ig_axi_len+1.
  - Simultaneous grant and return: os_cnt <= os_cnt + grant_beats - ret_beats. The return is not usable by that cycle's compare.
  - If the return exceeds os_cnt, saturate to 0 and set arb2reg_underflow (sticky until reset).
- Lowering reg2arb_os_limit below os_cnt blocks new grants until returns drain os_cnt. Already-issued requests are unaffected.
- Only clients with req_vld=1 are considered. A client dropping req_vld before grant is legal.

Optional Feature:
- Macro: NVDLA_MCIF_WRITE_ARB_WRR_EN.
- Defined (weighted round-robin):
  - The pointer does not advance while the last-granted client keeps requesting and its consecutive-grant count < weight+1.
  - Grant count resets when priority moves.
  - Weight 0 behaves as plain round-robin.
- Undefined: pure round-robin; reg2arb_wrr_weight is unused (port kept, ignored).

Decomposition:
- Shared package (nv_nvdla_mcif_pkg):
  - constant MCIF_WR_MAX_CLIENT=8
  - typedef for 2-bit axi len
  - typedef for 3-bit axi id
  - function len2beats(len) returning len+1
- One natural sub-module: mcif_rr_pick (priority-rotate one-hot picker, NUM_CLIENT wide, pointer input). It is reused by the read-side arbiter.

Test Plan:
- Limit=16; clients 0..4 request len=3 continuously; aw_rdy=1 and no returns -> grants 0,1,2,3 (16 beats), then stall; os_cnt=16; client 4 is not granted until a return.
- Continuing the previous test, eg2ig_axi_vld with len=3 in the same cycle that client 4 waits -> client 4 is granted the next cycle; os_cnt goes 16->12->16.
- Client 1 len=3, client 2 len=0, os_cnt=14, limit=16, pointer=0 -> no grant (no skip to client 2); after a return of 2 beats, client 1 is granted.
- aw_rdy=0 for 5 cycles with a grant held -> aw_vld/aw_id/aw_len stable and no further req_rdy; aw_rdy=1 with a pending requester -> back-to-back grant with no bubble.
- os_cnt=2, return len=3 -> os_cnt=0 and arb2reg_underflow=1, which persists until nvdla_core_rst.
- With NVDLA_MCIF_WRITE_ARB_WRR_EN, weight0=2, weight1=0, both requesting len=0 -> grant sequence 0,0,0,1,0,0,0,1.

Source files
------------

// File: rtl/mcif_write_ig_arb_pkg.sv
// Shared MCIF types and helpers used by the write/read ingress arbiters.
package nv_nvdla_mcif_pkg;

  localparam int MCIF_WR_MAX_CLIENT = 8;

  typedef logic [1:0] axi_len_t;
  typedef logic [2:0] axi_id_t;

  function automatic logic [2:0] len2beats(input axi_len_t len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage

// File: rtl/mcif_write_ig_arb_rr_pick.sv
// Rotating-priority picker: first requester strictly after ptr, wrapping.
module mcif_rr_pick
  import nv_nvdla_mcif_pkg::*;
#(
  parameter int NUM_CLIENT = 5
) (
  input  logic [NUM_CLIENT-1:0] req,
  input  axi_id_t               ptr,
  output logic [NUM_CLIENT-1:0] gnt,
  output logic                  vld,
  output axi_id_t               idx
);

  axi_id_t pos_s;

  // scan clients in priority order starting just after ptr
  always_comb begin
    gnt   = {NUM_CLIENT{1'b0}};
    vld   = 1'b0;
    idx   = 3'd0;
    pos_s = 3'd0;
    for (int i = 1; i <= NUM_CLIENT; i++) begin
      pos_s = axi_id_t'((int'(ptr) + i) % NUM_CLIENT);
      idx   = (!vld && req[pos_s]) ? pos_s : idx;
      vld   = vld | req[pos_s];
    end
    gnt[idx] = vld;
  end

endmodule

// File: rtl/mcif_write_ig_arb.sv
// MCIF write ingress arbiter: round-robin AW issue with outstanding-beat budget.
// Optional weighted round-robin via `define NVDLA_MCIF_WRITE_ARB_WRR_EN.
module mcif_write_ig_arb
  import nv_nvdla_mcif_pkg::*;
#(
  parameter int NUM_CLIENT = 5,
  parameter int CNT_W      = 9
) (
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  input  logic [NUM_CLIENT-1:0]   req_vld,
  input  logic [2*NUM_CLIENT-1:0] req_len,
  output logic [NUM_CLIENT-1:0]   req_rdy,
  output logic                    aw_vld,
  output logic [2:0]              aw_id,
  output logic [1:0]              aw_len,
  input  logic                    aw_rdy,
  input  logic                    eg2ig_axi_vld,
  input  logic [1:0]              eg2ig_axi_len,
  input  logic [7:0]              reg2arb_os_limit,
  input  logic [4*NUM_CLIENT-1:0] reg2arb_wrr_weight,
  output logic [CNT_W-1:0]        arb2reg_os_cnt,
  output logic                    arb2reg_underflow
);

  logic                  pick_vld_s;
  logic [NUM_CLIENT-1:0] pick_gnt_s;
  axi_id_t               pick_idx_s;
  logic                  hold_s;
  logic                  cand_vld_s;
  axi_id_t               cand_idx_s;
  axi_len_t              cand_len_s;
  logic [NUM_CLIENT-1:0] cand_oh_s;
  logic                  eval_s;
  logic                  fit_s;
  logic                  grant_s;
  logic [CNT_W-1:0]      grant_beats_s;
  logic [CNT_W-1:0]      ret_beats_s;
  logic [CNT_W-1:0]      sum_s;

  axi_id_t               ptr_r;
  logic                  aw_vld_r;
  axi_id_t               aw_id_r;
  axi_len_t              aw_len_r;
  logic [CNT_W-1:0]      os_cnt_r;
  logic                  underflow_r;

  mcif_rr_pick #(.NUM_CLIENT(NUM_CLIENT)) u_pick (
    .req (req_vld),
    .ptr (ptr_r),
    .gnt (pick_gnt_s),
    .vld (pick_vld_s),
    .idx (pick_idx_s)
  );

`ifdef NVDLA_MCIF_WRITE_ARB_WRR_EN
  logic [4:0] wrr_cnt_r;
  logic [4:0] wrr_lim_s;

  // keep priority on the last-granted client until it has used weight+1 grants
  always_comb begin
    wrr_lim_s = 5'd1;
    for (int i = 0; i < NUM_CLIENT; i++) begin
      wrr_lim_s = (ptr_r == axi_id_t'(i)) ? ({1'b0, reg2arb_wrr_weight[4*i +: 4]} + 5'd1) : wrr_lim_s;
    end
    hold_s = (wrr_cnt_r != 5'd0) && req_vld[ptr_r] && (wrr_cnt_r < wrr_lim_s);
  end

  // consecutive-grant counter, restarts whenever priority moves
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wrr_cnt_r <= 5'd0;
    end else if (grant_s) begin
      wrr_cnt_r <= hold_s ? (wrr_cnt_r + 5'd1) : 5'd1;
    end else begin
      wrr_cnt_r <= wrr_cnt_r;
    end
  end
`else
  logic unused_wrr_s;
  assign unused_wrr_s = ^{reg2arb_wrr_weight, pick_gnt_s};
  assign hold_s       = 1'b0;
`endif

  assign cand_vld_s = hold_s | pick_vld_s;
  assign cand_idx_s = hold_s ? ptr_r : pick_idx_s;

  // one-hot of the candidate and its burst length
  always_comb begin
    cand_oh_s  = {NUM_CLIENT{1'b0}};
    cand_len_s = 2'd0;
    for (int i = 0; i < NUM_CLIENT; i++) begin
      cand_oh_s[i] = cand_vld_s && (cand_idx_s == axi_id_t'(i));
      cand_len_s   = cand_oh_s[i] ? req_len[2*i +: 2] : cand_len_s;
    end
  end

  // a candidate that does not fit stalls everyone, so long bursts cannot starve
  assign eval_s  = !aw_vld_r || aw_rdy;
  assign fit_s   = (os_cnt_r + CNT_W'(len2beats(cand_len_s))) <= CNT_W'(reg2arb_os_limit);
  assign grant_s = !nvdla_core_rst && eval_s && cand_vld_s && fit_s;
  assign req_rdy = grant_s ? cand_oh_s : {NUM_CLIENT{1'b0}};

  assign grant_beats_s = grant_s ? CNT_W'(len2beats(cand_len_s)) : {CNT_W{1'b0}};
  assign ret_beats_s   = eg2ig_axi_vld ? CNT_W'(len2beats(eg2ig_axi_len)) : {CNT_W{1'b0}};
  assign sum_s         = os_cnt_r + grant_beats_s;

  // one-entry AW output stage and round-robin pointer
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      aw_vld_r <= 1'b0;
      aw_id_r  <= 3'd0;
      aw_len_r <= 2'd0;
      ptr_r    <= axi_id_t'(NUM_CLIENT - 1);
    end else if (grant_s) begin
      aw_vld_r <= 1'b1;
      aw_id_r  <= cand_idx_s;
      aw_len_r <= cand_len_s;
      ptr_r    <= cand_idx_s;
    end else if (aw_rdy) begin
      aw_vld_r <= 1'b0;
    end else begin
      aw_vld_r <= aw_vld_r;
    end
  end

  // outstanding-beat budget; an over-return saturates at zero and flags
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      os_cnt_r    <= {CNT_W{1'b0}};
      underflow_r <= 1'b0;
    end else if (ret_beats_s > sum_s) begin
      os_cnt_r    <= {CNT_W{1'b0}};
      underflow_r <= 1'b1;
    end else begin
      os_cnt_r    <= sum_s - ret_beats_s;
      underflow_r <= underflow_r;
    end
  end

  assign aw_vld            = aw_vld_r;
  assign aw_id             = aw_id_r;
  assign aw_len            = aw_len_r;
  assign arb2reg_os_cnt    = os_cnt_r;
  assign arb2reg_underflow = underflow_r;

endmodule
